// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the shared MIPS datapath.
//
// The FSM steps each instruction through FETCH / DECODE / EXEC / MEM / WB.
// This reuses one ALU and one memory port. Only the state is registered.
// Every other output is decoded combinationally from state, op, funct and zero.
// While reset is high, every write enable and both pulses (retire, illegal) are forced low.
//
// Optional feature macro: MC_CTRL_STALL_EN
//   defined   -> the mem_ready port exists, and FETCH/MEM wait for mem_ready = 1
//   undefined -> no mem_ready port; behaves as if mem_ready were tied to 1
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   op         in   IR[31:26]
//   funct      in   IR[5:0]
//   zero       in   ALU result == 0
//   mem_ready  in   memory handshake (MC_CTRL_STALL_EN only)
//   pc_we      out  PC write
//   pc_src     out  0 PC+4, 1 branch target, 2 jump target, 3 GPR[rs]
//   ir_we      out  IR write
//   reg_we     out  GPR write
//   reg_dst    out  0 rt, 1 rd, 2 $31
//   wd_sel     out  0 ALU, 1 memory data, 2 current PC
//   alu_src    out  0 GPR[rt], 1 extended immediate
//   ext_op     out  0 zero-extend, 1 sign-extend, 2 imm << 16
//   alu_op     out  0 add, 1 sub, 2 or
//   mem_we     out  memory write
//   state      out  current state encoding (FETCH 0 .. WB 4)
//   retire     out  pulse in the final cycle of each instruction
//   illegal    out  pulse in DECODE for an unsupported encoding

module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
`ifdef MC_CTRL_STALL_EN
    input  logic       mem_ready,
`endif
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       ir_we,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       alu_src,
    output logic [1:0] ext_op,
    output logic [1:0] alu_op,
    output logic       mem_we,
    output logic [2:0] state,
    output logic       retire,
    output logic       illegal
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        InstrAddu,
        InstrSubu,
        InstrJr,
        InstrNop,
        InstrOri,
        InstrLw,
        InstrSw,
        InstrBeq,
        InstrLui,
        InstrJ,
        InstrJal,
        InstrIllegal
    } instr_e;

    state_e state_q;
    state_e state_d;
    instr_e instr;
    logic   mem_rdy;

    // Unconditioned enables/pulses; reset masks them at the ports.
    logic pc_we_c;
    logic ir_we_c;
    logic reg_we_c;
    logic mem_we_c;
    logic retire_c;
    logic illegal_c;

`ifdef MC_CTRL_STALL_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    // Instruction class from op/funct; anything unrecognised is illegal.
    always_comb begin
        instr = InstrIllegal;
        case (op)
            6'h00: begin
                case (funct)
                    6'h21:   instr = InstrAddu;
                    6'h23:   instr = InstrSubu;
                    6'h08:   instr = InstrJr;
                    6'h00:   instr = InstrNop;
                    default: instr = InstrIllegal;
                endcase
            end
            6'h0d:   instr = InstrOri;
            6'h23:   instr = InstrLw;
            6'h2b:   instr = InstrSw;
            6'h04:   instr = InstrBeq;
            6'h0f:   instr = InstrLui;
            6'h02:   instr = InstrJ;
            6'h03:   instr = InstrJal;
            default: instr = InstrIllegal;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = StFetch;
        pc_we_c   = 1'b0;
        pc_src    = 2'd0;
        ir_we_c   = 1'b0;
        reg_we_c  = 1'b0;
        reg_dst   = 2'd0;
        wd_sel    = 2'd0;
        alu_src   = 1'b0;
        ext_op    = 2'd0;
        alu_op    = 2'd0;
        mem_we_c  = 1'b0;
        retire_c  = 1'b0;
        illegal_c = 1'b0;

        unique case (state_q)
            StFetch: begin
                if (mem_rdy) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = StDecode;
                end else begin
                    state_d = StFetch;
                end
            end

            StDecode: begin
                state_d = StFetch;
                case (instr)
                    InstrJ: begin
                        pc_we_c  = 1'b1;
                        pc_src   = 2'd2;
                        retire_c = 1'b1;
                    end
                    InstrJal: begin
                        pc_we_c  = 1'b1;
                        pc_src   = 2'd2;
                        reg_we_c = 1'b1;
                        reg_dst  = 2'd2;
                        wd_sel   = 2'd2;
                        retire_c = 1'b1;
                    end
                    InstrJr: begin
                        pc_we_c  = 1'b1;
                        pc_src   = 2'd3;
                        retire_c = 1'b1;
                    end
                    InstrNop: begin
                        retire_c = 1'b1;
                    end
                    InstrIllegal: begin
                        illegal_c = 1'b1;
                        retire_c  = 1'b1;
                    end
                    default: begin
                        state_d = StExec;
                    end
                endcase
            end

            StExec: begin
                state_d = StFetch;
                case (instr)
                    InstrBeq: begin
                        alu_op   = 2'd1;
                        pc_src   = zero ? 2'd1 : 2'd0;
                        pc_we_c  = zero;
                        retire_c = 1'b1;
                    end
                    InstrAddu: begin
                        alu_op  = 2'd0;
                        state_d = StWb;
                    end
                    InstrSubu: begin
                        alu_op  = 2'd1;
                        state_d = StWb;
                    end
                    InstrOri: begin
                        alu_op  = 2'd2;
                        alu_src = 1'b1;
                        ext_op  = 2'd0;
                        state_d = StWb;
                    end
                    InstrLui: begin
                        // The datapath forces ALU input A to zero for lui.
                        alu_op  = 2'd2;
                        alu_src = 1'b1;
                        ext_op  = 2'd2;
                        state_d = StWb;
                    end
                    InstrLw, InstrSw: begin
                        alu_op  = 2'd0;
                        alu_src = 1'b1;
                        ext_op  = 2'd1;
                        state_d = StMem;
                    end
                    default: begin
                        state_d = StFetch;
                    end
                endcase
            end

            StMem: begin
                if (!mem_rdy) begin
                    state_d = StMem;
                end else if (instr == InstrSw) begin
                    mem_we_c = 1'b1;
                    retire_c = 1'b1;
                    state_d  = StFetch;
                end else if (instr == InstrLw) begin
                    state_d = StWb;
                end else begin
                    state_d = StFetch;
                end
            end

            StWb: begin
                reg_we_c = 1'b1;
                retire_c = 1'b1;
                state_d  = StFetch;
                case (instr)
                    InstrAddu, InstrSubu: begin
                        reg_dst = 2'd1;
                        wd_sel  = 2'd0;
                    end
                    InstrLw: begin
                        reg_dst = 2'd0;
                        wd_sel  = 2'd1;
                    end
                    default: begin
                        reg_dst = 2'd0;
                        wd_sel  = 2'd0;
                    end
                endcase
            end

            default: begin
                state_d = StFetch;
            end
        endcase
    end

    assign pc_we   = pc_we_c   & ~reset;
    assign ir_we   = ir_we_c   & ~reset;
    assign reg_we  = reg_we_c  & ~reset;
    assign mem_we  = mem_we_c  & ~reset;
    assign retire  = retire_c  & ~reset;
    assign illegal = illegal_c & ~reset;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl.
//
// For every instruction issued, the reference model builds the full
// cycle-by-cycle list of expected outputs. It derives this list from the
// per-instruction step rules. The list includes any stall cycles when
// MC_CTRL_STALL_EN is defined. The bench then replays that list against the DUT.

module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
`ifdef MC_CTRL_STALL_EN
    logic       mem_ready;
`endif
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [1:0] alu_op;
    logic       mem_we;
    logic [2:0] state;
    logic       retire;
    logic       illegal;

    always #5 clk = ~clk;

    mc_ctrl u_dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
`ifdef MC_CTRL_STALL_EN
        .mem_ready (mem_ready),
`endif
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .ir_we     (ir_we),
        .reg_we    (reg_we),
        .reg_dst   (reg_dst),
        .wd_sel    (wd_sel),
        .alu_src   (alu_src),
        .ext_op    (ext_op),
        .alu_op    (alu_op),
        .mem_we    (mem_we),
        .state     (state),
        .retire    (retire),
        .illegal   (illegal)
    );

    typedef struct packed {
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       alu_src;
        logic [1:0] ext_op;
        logic [1:0] alu_op;
        logic       mem_we;
        logic [2:0] state;
        logic       retire;
        logic       illegal;
    } outs_t;

    typedef struct {
        outs_t      exp;
        logic [5:0] op;
        logic [5:0] funct;
        logic       z;
        logic       rdy;
    } step_t;

    typedef enum int {
        KAddu, KSubu, KJr, KNop, KOri, KLw, KSw, KBeq, KLui, KJ, KJal, KIll
    } kind_e;

    step_t trace_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_ret_dut = 0;
    int    n_ret_exp = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic kind_e classify(input logic [5:0] o, input logic [5:0] f);
        kind_e k;
        case (o)
            6'h00: begin
                case (f)
                    6'h21:   k = KAddu;
                    6'h23:   k = KSubu;
                    6'h08:   k = KJr;
                    6'h00:   k = KNop;
                    default: k = KIll;
                endcase
            end
            6'h0d:   k = KOri;
            6'h23:   k = KLw;
            6'h2b:   k = KSw;
            6'h04:   k = KBeq;
            6'h0f:   k = KLui;
            6'h02:   k = KJ;
            6'h03:   k = KJal;
            default: k = KIll;
        endcase
        return k;
    endfunction

    function automatic outs_t blank(input logic [2:0] s);
        outs_t o = '0;
        o.state = s;
        return o;
    endfunction

    function automatic logic rbit();
        return ($urandom_range(0, 1) == 1);
    endfunction

    task automatic push(input outs_t e, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input logic rdy);
        step_t s;
        s.exp   = e;
        s.op    = o;
        s.funct = f;
        s.z     = z;
        s.rdy   = rdy;
        trace_q.push_back(s);
    endtask

    // Expected trace for one instruction. nf/nm are stall cycles in FETCH/MEM (-1 = random).
    task automatic gen_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int nf, input int nm);
        kind_e k;
        outs_t e;
        int    fs;
        int    ms;
        k  = classify(o, f);
`ifdef MC_CTRL_STALL_EN
        fs = (nf < 0) ? int'($urandom_range(0, 2)) : nf;
        ms = (nm < 0) ? int'($urandom_range(0, 3)) : nm;
`else
        fs = 0;
        ms = 0;
        if (nf + nm < -2) fs = 0;
`endif
        n_ret_exp++;

        for (int i = 0; i < fs; i++) push(blank(3'd0), o, f, rbit(), 1'b0);
        e = blank(3'd0);
        e.ir_we = 1'b1;
        e.pc_we = 1'b1;
        push(e, o, f, rbit(), 1'b1);

        e = blank(3'd1);
        case (k)
            KJ:   begin e.pc_we = 1; e.pc_src = 2; e.retire = 1; end
            KJal: begin
                e.pc_we = 1; e.pc_src = 2; e.reg_we = 1; e.reg_dst = 2; e.wd_sel = 2;
                e.retire = 1;
            end
            KJr:  begin e.pc_we = 1; e.pc_src = 3; e.retire = 1; end
            KNop: e.retire = 1;
            KIll: begin e.illegal = 1; e.retire = 1; end
            default: ;
        endcase
        push(e, o, f, rbit(), rbit());
        if (e.retire) return;

        e = blank(3'd2);
        case (k)
            KBeq: begin
                e.alu_op = 1;
                e.retire = 1;
                if (z) begin e.pc_we = 1; e.pc_src = 1; end
            end
            KAddu: e.alu_op = 0;
            KSubu: e.alu_op = 1;
            KOri:  begin e.alu_op = 2; e.alu_src = 1; e.ext_op = 0; end
            KLui:  begin e.alu_op = 2; e.alu_src = 1; e.ext_op = 2; end
            default: begin e.alu_op = 0; e.alu_src = 1; e.ext_op = 1; end
        endcase
        push(e, o, f, (k == KBeq) ? z : rbit(), rbit());
        if (k == KBeq) return;

        if (k == KLw || k == KSw) begin
            for (int i = 0; i < ms; i++) push(blank(3'd3), o, f, rbit(), 1'b0);
            e = blank(3'd3);
            if (k == KSw) begin e.mem_we = 1; e.retire = 1; end
            push(e, o, f, rbit(), 1'b1);
            if (k == KSw) return;
        end

        e = blank(3'd4);
        e.reg_we = 1;
        e.retire = 1;
        if (k == KAddu || k == KSubu) e.reg_dst = 1;
        if (k == KLw) e.wd_sel = 1;
        push(e, o, f, rbit(), rbit());
    endtask

    // Called at posedge+1; applies one step, checks at negedge, returns at posedge+1.
    task automatic run_step();
        step_t s;
        outs_t g;
        s = trace_q.pop_front();
        op    = s.op;
        funct = s.funct;
        zero  = s.z;
`ifdef MC_CTRL_STALL_EN
        mem_ready = s.rdy;
`endif
        @(negedge clk);
        g = {pc_we, pc_src, ir_we, reg_we, reg_dst, wd_sel, alu_src, ext_op, alu_op,
             mem_we, state, retire, illegal};
        check_eq($sformatf("st%0d_op%02h_fn%02h", s.exp.state, s.op, s.funct),
                 32'(g), 32'(s.exp));
        if (retire === 1'b1) n_ret_dut++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int nf, input int nm);
        gen_instr(o, f, z, nf, nm);
        while (trace_q.size() > 0) run_step();
    endtask

    task automatic run_random();
        logic [5:0] o;
        logic [5:0] f;
        int         sel;
        int         guard;
        sel = $urandom_range(0, 12);
        f   = 6'($urandom);
        case (sel)
            0:  begin o = 6'h00; f = 6'h21; end
            1:  begin o = 6'h00; f = 6'h23; end
            2:  begin o = 6'h00; f = 6'h08; end
            3:  begin o = 6'h00; f = 6'h00; end
            4:  o = 6'h0d;
            5:  o = 6'h23;
            6:  o = 6'h2b;
            7:  o = 6'h04;
            8:  o = 6'h0f;
            9:  o = 6'h02;
            10: o = 6'h03;
            11: begin
                o = 6'h3f;
                guard = 0;
                do begin
                    o = 6'($urandom);
                    guard++;
                end while (classify(o, 6'h00) != KIll && guard < 100);
                if (classify(o, 6'h00) != KIll) o = 6'h3f;
            end
            default: begin
                o = 6'h00;
                guard = 0;
                do begin
                    f = 6'($urandom);
                    guard++;
                end while (classify(6'h00, f) != KIll && guard < 100);
                if (classify(6'h00, f) != KIll) f = 6'h2a;
            end
        endcase
        run_instr(o, f, rbit(), -1, -1);
    endtask

    initial begin
        reset = 1'b1;
        op    = 6'h00;
        funct = 6'h00;
        zero  = 1'b0;
`ifdef MC_CTRL_STALL_EN
        mem_ready = 1'b1;
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            op    = 6'($urandom);
            funct = 6'($urandom);
            zero  = rbit();
            @(negedge clk);
            check_eq($sformatf("rst_en%0d", i),
                     32'({pc_we, ir_we, reg_we, mem_we, retire, illegal}), 32'd0);
            check_eq($sformatf("rst_state%0d", i), 32'(state), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed sequence.
        run_instr(6'h0d, 6'h34, 1'b0, 0, 0);   // ori $1,$0,0x1234
        run_instr(6'h00, 6'h21, 1'b0, 0, 0);   // addu $2,$1,$1
        run_instr(6'h2b, 6'h00, 1'b0, 0, 0);   // sw
        run_instr(6'h23, 6'h00, 1'b0, 0, 0);   // lw
        run_instr(6'h04, 6'h01, 1'b1, 0, 0);   // beq taken
        run_instr(6'h04, 6'h01, 1'b0, 0, 0);   // beq not taken
        run_instr(6'h03, 6'h10, 1'b0, 0, 0);   // jal
        run_instr(6'h00, 6'h08, 1'b0, 0, 0);   // jr $31
        run_instr(6'h3f, 6'h00, 1'b0, 0, 0);   // illegal op
        run_instr(6'h00, 6'h2a, 1'b1, 0, 0);   // illegal funct
        run_instr(6'h00, 6'h00, 1'b0, 0, 0);   // nop
        run_instr(6'h0f, 6'h00, 1'b0, 0, 0);   // lui
        run_instr(6'h00, 6'h23, 1'b1, 0, 0);   // subu
        run_instr(6'h02, 6'h3c, 1'b0, 0, 0);   // j
        run_instr(6'h2b, 6'h04, 1'b0, 0, 3);   // sw with 3 MEM stall cycles

        for (int i = 0; i < 400; i++) run_random();

        // Reset while an lw is in EXEC: no writes, then FETCH after release.
        gen_instr(6'h23, 6'h00, 1'b0, 0, 0);
        run_step();
        run_step();
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_en", 32'({pc_we, ir_we, reg_we, mem_we, retire, illegal}), 32'd0);
        check_eq("midrst_state_exec", 32'(state), 32'd2);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("midrst_en2", 32'({pc_we, ir_we, reg_we, mem_we, retire, illegal}), 32'd0);
        check_eq("midrst_state_fetch", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        trace_q.delete();
        n_ret_exp--;

        run_instr(6'h23, 6'h00, 1'b0, 0, 0);
        for (int i = 0; i < 20; i++) run_random();

        check_eq("retire_count", 32'(n_ret_dut), 32'(n_ret_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
